// File: rtl/pixel_readout.sv
// Column-side pixel readout: drives the ADC ramp onto the shared pixel bus,
// releases the bus during read strobes, captures pixel codes tagged with the
// pixel index and buffers them in a show-ahead FIFO with a valid/ready stream.
// Optional build macro: PIXEL_READOUT_GRAY_EN (Gray-coded ramp on the bus and
// Gray-to-binary decode of captured codes).
module pixel_readout #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_PIX    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       convert,
  input  logic [NUM_PIX-1:0]         read_sel,
  input  logic [DATA_W-1:0]          bus_in,
  output logic [DATA_W-1:0]          ramp_data,
  output logic                       ramp_oe,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_PIX)-1:0] out_pix,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_done,
  output logic                       overflow,
  output logic                       proto_err
);

  localparam int unsigned PIX_W = $clog2(NUM_PIX);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_RD_TURN,
    ST_RD_HOLD
  } state_t;

  state_t               r_state;
  logic [PIX_W-1:0]     r_idx;
  logic                 r_proto_err;
  logic                 r_frame_done;
  logic                 r_overflow;
  logic [DATA_W-1:0]    r_ramp_bin;
  logic [DATA_W-1:0]    w_ramp_next;
  logic [DATA_W-1:0]    r_mem_data [FIFO_DEPTH];
  logic [PIX_W-1:0]     r_mem_pix  [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic                 w_sel_any;
  logic                 w_sel_onehot;
  logic                 w_sel_other;
  logic [PIX_W-1:0]     w_sel_idx;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr;
  logic [DATA_W-1:0]    w_cap_data;

  // Index of the highest set strobe bit (only meaningful when one-hot)
  function automatic logic [PIX_W-1:0] sel_index(input logic [NUM_PIX-1:0] s);
    logic [PIX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_PIX; i++) begin
      if (s[i]) idx = PIX_W'(i);
    end
    return idx;
  endfunction

`ifdef PIXEL_READOUT_GRAY_EN
  logic [DATA_W-1:0] r_ramp_gray;

  function automatic logic [DATA_W-1:0] bin2gray(input logic [DATA_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b = '0;
    b[DATA_W-1] = g[DATA_W-1];
    for (int i = int'(DATA_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign ramp_data  = r_ramp_gray;
  assign w_cap_data = gray2bin(bus_in);
`else
  assign ramp_data  = r_ramp_bin;
  assign w_cap_data = bus_in;
`endif

  // Strobe decode
  assign w_sel_any    = |read_sel;
  assign w_sel_onehot = w_sel_any && ((read_sel & (read_sel - NUM_PIX'(1))) == '0);
  assign w_sel_idx    = sel_index(read_sel);
  assign w_sel_other  = |(read_sel & ~(NUM_PIX'(1) << r_idx));

  // Bus is released whenever any strobe is high
  assign ramp_oe = (read_sel == '0);

  // FIFO handshake; a pop in the same cycle makes room for a push into a full FIFO
  assign w_push = (r_state == ST_RD_TURN) && read_sel[r_idx];
  assign w_pop  = out_valid && out_ready;
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);

  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem_data[r_rd_ptr];
  assign out_pix    = r_mem_pix[r_rd_ptr];
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign proto_err  = r_proto_err;

  // Saturating ramp increment while converting, cleared otherwise
  always_comb begin
    w_ramp_next = '0;
    if (convert) begin
      if (r_ramp_bin == '1) w_ramp_next = r_ramp_bin;
      else                  w_ramp_next = r_ramp_bin + DATA_W'(1);
    end
  end

  // Ramp counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ramp_bin  <= '0;
`ifdef PIXEL_READOUT_GRAY_EN
      r_ramp_gray <= '0;
`endif
    end else begin
      r_ramp_bin  <= w_ramp_next;
`ifdef PIXEL_READOUT_GRAY_EN
      r_ramp_gray <= bin2gray(w_ramp_next);
`endif
    end
  end

  // Readout sequencer with protocol checking and frame_done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_proto_err  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_push && (r_idx == PIX_W'(NUM_PIX - 1));
      case (r_state)
        ST_IDLE: begin
          if (convert) begin
            r_state <= ST_CONV;
            if (w_sel_any) r_proto_err <= 1'b1;
          end else if (w_sel_onehot) begin
            r_state <= ST_RD_TURN;
            r_idx   <= w_sel_idx;
          end else if (w_sel_any) begin
            r_proto_err <= 1'b1;
          end
        end
        ST_CONV: begin
          if (!convert)       r_state     <= ST_IDLE;
          else if (w_sel_any) r_proto_err <= 1'b1;
        end
        ST_RD_TURN: begin
          if (read_sel[r_idx]) begin
            r_state <= ST_RD_HOLD;
            if (w_sel_other) r_proto_err <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_proto_err <= 1'b1;
          end
        end
        ST_RD_HOLD: begin
          if (!w_sel_any)       r_state     <= ST_IDLE;
          else if (w_sel_other) r_proto_err <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output FIFO storage, pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pix[i]  <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem_data[r_wr_ptr] <= w_cap_data;
        r_mem_pix[r_wr_ptr]  <= r_idx;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_wr) r_overflow <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Scoreboard bench for pixel_readout: stimulus pushes expected stream entries,
// a negedge monitor pops and compares whenever the DUT hands one over.
// Honours PIXEL_READOUT_GRAY_EN to match the optional Gray build.
module tb_pixel_readout;

  logic       clk = 1'b0;
  logic       reset;
  logic       convert;
  logic [3:0] read_sel;
  logic [7:0] bus_in;
  logic [7:0] ramp_data;
  logic       ramp_oe;
  logic [7:0] out_data;
  logic [1:0] out_pix;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic       overflow;
  logic       proto_err;

  typedef struct packed {
    logic [1:0] pix;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pixel_readout #(.DATA_W(8), .NUM_PIX(4), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .convert    (convert),
    .read_sel   (read_sel),
    .bus_in     (bus_in),
    .ramp_data  (ramp_data),
    .ramp_oe    (ramp_oe),
    .out_data   (out_data),
    .out_pix    (out_pix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .overflow   (overflow),
    .proto_err  (proto_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Ramp value as seen on the bus for binary counter value k
  function automatic logic [7:0] exp_ramp(input logic [7:0] k);
`ifdef PIXEL_READOUT_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  // Bus encoding of a pixel code so that the captured out_data equals v
  function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef PIXEL_READOUT_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    convert  = 1'b0;
    read_sel = '0;
    bus_in   = '0;
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
  endtask

  // Monitor: compare every accepted stream beat against the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stream_unexpected: got pix %0d data 0x%0h, expected nothing at %0t",
                 out_pix, out_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stream_pix", 32'(out_pix), 32'(e.pix));
        chk("stream_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    logic [7:0] fr_data [4];
    fr_data[0] = 8'h11; fr_data[1] = 8'h22; fr_data[2] = 8'h33; fr_data[3] = 8'h44;

    reset     = 1'b0;
    convert   = 1'b0;
    read_sel  = '0;
    bus_in    = '0;
    out_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ramp", 32'(ramp_data), 32'h0);
    chk("rst_oe", 32'(ramp_oe), 32'h1);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_pix", 32'(out_pix), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_perr", 32'(proto_err), 32'h0);

    // Ramp counting, clear, saturation
    convert = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("ramp_count", 32'(ramp_data), 32'(exp_ramp(8'(k))));
      chk("ramp_oe_conv", 32'(ramp_oe), 32'h1);
    end
    convert = 1'b0;
    tick();
    chk("ramp_clear", 32'(ramp_data), 32'h0);
    convert = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    chk("ramp_sat", 32'(ramp_data), 32'(exp_ramp(8'hFF)));
    convert = 1'b0;
    tick();
    chk("ramp_perr", 32'(proto_err), 32'h0);

    // Frame readout with out_ready high
    do_reset();
    out_ready = 1'b1;
    convert   = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    convert = 1'b0;
    tick();
    for (int p = 0; p < 4; p++) begin
      read_sel = 4'(1 << p);
      bus_in   = enc(fr_data[p]);
      exp_q.push_back('{pix: 2'(p), data: fr_data[p]});
      #1;
      chk("frame_oe_low", 32'(ramp_oe), 32'h0);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("frame_done", 32'(frame_done), 32'((p == 3) && (c == 1)));
        chk("frame_oe_hold", 32'(ramp_oe), 32'h0);
      end
      read_sel = '0;
      bus_in   = '0;
      #1;
      chk("frame_oe_rel", 32'(ramp_oe), 32'h1);
      tick();
      chk("frame_done_idle", 32'(frame_done), 32'h0);
    end
    for (int k = 0; k < 4; k++) tick();
    chk("frame_drain", 32'(exp_q.size()), 32'h0);
    chk("frame_perr", 32'(proto_err), 32'h0);
    chk("frame_ovf", 32'(overflow), 32'h0);

    // Backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      read_sel = 4'b0001;
      bus_in   = enc(8'(k));
      if (k <= 8) exp_q.push_back('{pix: 2'd0, data: 8'(k)});
      tick();
      tick();
      read_sel = '0;
      bus_in   = '0;
      tick();
      if (k == 8) chk("ovf_at_full", 32'(overflow), 32'h0);
    end
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_head_valid", 32'(out_valid), 32'h1);
    chk("ovf_head_data", 32'(out_data), 32'h1);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("ovf_drain", 32'(exp_q.size()), 32'h0);
    chk("ovf_empty", 32'(out_valid), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Protocol error: single-cycle strobe
    do_reset();
    read_sel = 4'b0001;
    bus_in   = 8'h5A;
    tick();
    read_sel = '0;
    tick();
    tick();
    chk("perr_short", 32'(proto_err), 32'h1);
    chk("perr_short_nov", 32'(out_valid), 32'h0);

    // Protocol error: two strobes at once
    do_reset();
    read_sel = 4'b0011;
    bus_in   = 8'hA5;
    tick();
    read_sel = '0;
    tick();
    tick();
    chk("perr_multi", 32'(proto_err), 32'h1);
    chk("perr_multi_nov", 32'(out_valid), 32'h0);

    // Protocol error: strobe during conversion, ramp keeps counting
    do_reset();
    convert = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    read_sel = 4'b0100;
    bus_in   = 8'h77;
    tick();
    chk("perr_conv_ramp6", 32'(ramp_data), 32'(exp_ramp(8'd6)));
    tick();
    chk("perr_conv_ramp7", 32'(ramp_data), 32'(exp_ramp(8'd7)));
    read_sel = '0;
    tick();
    chk("perr_conv", 32'(proto_err), 32'h1);
    chk("perr_conv_ramp8", 32'(ramp_data), 32'(exp_ramp(8'd8)));
    chk("perr_conv_nov", 32'(out_valid), 32'h0);
    convert = 1'b0;
    tick();

    // Reset in the middle of a frame
    do_reset();
    out_ready = 1'b0;
    read_sel  = 4'b0011;
    tick();
    read_sel = '0;
    tick();
    for (int p = 0; p < 2; p++) begin
      read_sel = 4'(1 << p);
      bus_in   = enc(fr_data[p]);
      tick();
      tick();
      tick();
      read_sel = '0;
      tick();
    end
    chk("mid_pre_valid", 32'(out_valid), 32'h1);
    chk("mid_pre_perr", 32'(proto_err), 32'h1);
    convert = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    convert = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_perr", 32'(proto_err), 32'h0);
    chk("mid_ovf", 32'(overflow), 32'h0);
    chk("mid_ramp", 32'(ramp_data), 32'h0);
    chk("mid_data", 32'(out_data), 32'h0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("mid_still_empty", 32'(out_valid), 32'h0);

`ifdef PIXEL_READOUT_GRAY_EN
    // Gray-coded ramp and decoded capture
    begin
      logic [7:0] g_ramp [5];
      g_ramp[0] = 8'h01; g_ramp[1] = 8'h03; g_ramp[2] = 8'h02;
      g_ramp[3] = 8'h06; g_ramp[4] = 8'h07;
      do_reset();
      convert = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("gray_ramp", 32'(ramp_data), 32'(g_ramp[k]));
      end
      convert   = 1'b0;
      tick();
      out_ready = 1'b1;
      read_sel  = 4'b0010;
      bus_in    = 8'h0C;
      exp_q.push_back('{pix: 2'd1, data: 8'h08});
      tick();
      tick();
      tick();
      read_sel = '0;
      tick();
      tick();
      chk("gray_drain", 32'(exp_q.size()), 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_readout.md
Name: pixel_readout

Overview:
- Column-side digital readout for the pixel array. It is the bus master opposite the pixel sensors.
- While the controller asserts `convert`, it drives the digital ADC ramp onto the shared pixel data bus.
- During each per-pixel read strobe it releases the bus and samples the latched pixel code.
- Captured samples are tagged with the pixel index and buffered in a FIFO with a valid/ready output stream for downstream readout.

Parameters:
- DATA_W, 8, ramp/pixel code width
- NUM_PIX, 4, number of read strobes (read, read2, read3, read4)
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next posedge)
- convert  input  1  ADC conversion phase from pixel state FSM
- read_sel  input  NUM_PIX  one-hot read strobes; bit i = pixel i read
- bus_in  input  DATA_W  sampled value of the tristate pixel data bus
- ramp_data  output  DATA_W  digital ramp value to drive onto the bus
- ramp_oe  output  1  bus drive enable for ramp_data (pad tristate control)
- out_data  output  DATA_W  captured pixel code
- out_pix  output  $clog2(NUM_PIX)  pixel index of out_data
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accept
- frame_done  output  1  1-cycle pulse after last pixel captured
- overflow  output  1  sticky: sample dropped on full FIFO
- proto_err  output  1  sticky: protocol violation (see below)

Behaviour:
- Reset values:
  - ramp_data=0, ramp_oe=1
  - out_valid=0, out_data=0, out_pix=0
  - frame_done=0, overflow=0, proto_err=0
  - FIFO empty, FSM=IDLE
- Reset mid-operation aborts everything: FIFO flushed, sticky flags cleared.
- ramp_oe = (read_sel==0), combinational. The bus is released in any cycle in which a strobe is high.
- Ramp counter, registered:
  - convert==0 → ramp_data<=0.
  - convert==1 → ramp_data<=ramp_data+1. First posedge with convert high gives 1.
  - Saturates at all-ones and does not wrap.
- FSM states: IDLE, CONV, RD_TURN, RD_HOLD.
- IDLE:
  - convert → CONV.
  - Exactly one read_sel bit → RD_TURN; latch index i.
- CONV:
  - convert falls → IDLE.
  - Any read_sel bit while convert=1 → set proto_err, stay in CONV. The ramp keeps counting and there is no capture.
- RD_TURN, bus turnaround cycle:
  - If the strobe i is still high → RD_HOLD and capture bus_in this cycle. Push {i, bus_in} on the next posedge.
  - If the strobe has dropped (1-cycle strobe) → proto_err, IDLE, no capture.
- RD_HOLD:
  - Wait until read_sel==0 → IDLE. Exactly one capture per strobe, however long it lasts.
  - A different bit asserting while in RD_HOLD → proto_err. It is ignored until return to IDLE.
- More than one read_sel bit set in IDLE → proto_err, no capture, stay IDLE.
- FIFO:
  - Show-ahead; out_data/out_pix valid whenever out_valid.
  - Pop on out_valid&&out_ready.
  - Push when full: the sample is dropped, overflow set. A simultaneous pop frees space, so push succeeds when full && pop.
  - Push into an empty FIFO gives out_valid=1 on the cycle after the push posedge (1-cycle latency).
- frame_done:
  - Pulses one cycle, concurrent with the push of index NUM_PIX-1.
  - Pulses even if that push overflowed.

Optional Feature:
- Macro: PIXEL_READOUT_GRAY_EN.
- Defined:
  - ramp_data is driven as the Gray code of the internal binary counter; saturation is applied on the binary value.
  - bus_in is Gray-to-binary converted before the FIFO push, so out_data is always binary.
- Undefined:
  - Plain binary ramp and direct capture.
  - Conversion logic absent.

Test Plan:
- Ramp: reset released, convert high 10 cycles → ramp_data 1..10, ramp_oe=1. Convert low → ramp_data=0 next posedge. Hold convert 300 cycles (DATA_W=8) → ramp_data sticks at 255.
- Frame readout:
  - convert 100 cycles, then strobes read_sel=0001,0010,0100,1000, each 3 cycles with bus_in=0x11,0x22,0x33,0x44 and 1 idle cycle between.
  - With out_ready=1, expect stream (0,0x11),(1,0x22),(2,0x33),(3,0x44).
  - frame_done single pulse; ramp_oe=0 exactly during strobes.
- Backpressure/overflow: out_ready=0, 10 single-pixel strobes with data 1..10 → FIFO holds 1..8, overflow=1. Then out_ready=1 → pops exactly 1..8.
- Protocol errors:
  - 1-cycle strobe → proto_err=1, no FIFO entry.
  - After reset, read_sel=0011 → proto_err=1, no entry.
  - After reset, strobe during convert → proto_err=1, ramp continues.
- Reset mid-frame: reset low for 1 cycle after 2 captures with out_ready=0 → out_valid=0, FIFO empty, flags 0, ramp_data=0.
- Gray (macro defined): convert 5 cycles → ramp_data 1,3,2,6,7. bus_in=0x0C during a strobe → out_data=0x08.
